// File: rtl/abc_seq_pkg.sv
// abc_seq_pkg: shared state indices, one-hot state vectors and symbol constants for abc_seq_tx
package abc_seq_pkg;
  localparam int S_IDLE = 0;
  localparam int S_LOAD = 1;
  localparam int S_EMIT = 2;
  localparam int S_PAUSE = 3;
  localparam int S_GAP = 4;
  localparam int S_DONE = 5;
  localparam int N_ST = 6;
  localparam int SYM_W = 3;
  localparam logic [SYM_W-1:0] IDLE_SYM = '0;
  localparam logic [N_ST-1:0] ST_IDLE = N_ST'(1 << S_IDLE);
  localparam logic [N_ST-1:0] ST_LOAD = N_ST'(1 << S_LOAD);
  localparam logic [N_ST-1:0] ST_EMIT = N_ST'(1 << S_EMIT);
  localparam logic [N_ST-1:0] ST_PAUSE = N_ST'(1 << S_PAUSE);
  localparam logic [N_ST-1:0] ST_GAP = N_ST'(1 << S_GAP);
  localparam logic [N_ST-1:0] ST_DONE = N_ST'(1 << S_DONE);

  function automatic logic onehot(input logic [N_ST-1:0] s);
    return (s != '0) && ((s & (s - 1'b1)) == '0);
  endfunction
endpackage

// File: rtl/abc_seq_tx.sv
// abc_seq_tx: accepts a frame of {a,b,c} symbols and plays it out with per-symbol hold, stall, idle gap and done pulse
module abc_seq_tx
  import abc_seq_pkg::*;
#(
  parameter int N_SYM = 4,
  parameter int HOLD_W = 2,
  parameter int GAP_CYC = 2,
  localparam int IW = (N_SYM > 1) ? $clog2(N_SYM) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_SYM*SYM_W-1:0] in_data,
  input  logic [HOLD_W-1:0]      in_hold,
  input  logic                   stall,
  output logic                   a,
  output logic                   b,
  output logic                   c,
  output logic                   sym_valid,
  output logic [IW-1:0]          sym_idx,
  output logic                   busy,
  output logic                   done
);
  localparam int GW = $clog2(GAP_CYC) + 1;

  logic [N_ST-1:0] state_q, state_d;
  logic [N_SYM*SYM_W-1:0] shift_q, shift_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hcnt_q, hcnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    hold_d = hold_q;
    hcnt_d = hcnt_q;
    idx_d = idx_q;
    gap_d = gap_q;
    if (!onehot(state_q)) begin
      state_d = ST_IDLE;
    end else if (state_q[S_IDLE]) begin
      if (in_valid) begin
        shift_d = in_data;
        hold_d = in_hold;
        idx_d = '0;
        state_d = ST_LOAD;
      end
    end else if (state_q[S_LOAD]) begin
      idx_d = '0;
      hcnt_d = hold_q;
      state_d = ST_EMIT;
    end else if (state_q[S_EMIT]) begin
      if (stall) state_d = ST_PAUSE;
      else if (hcnt_q != '0) hcnt_d = hcnt_q - 1'b1;
      else if (idx_q == IW'(N_SYM - 1)) begin
        gap_d = '0;
        state_d = ST_GAP;
      end else begin
        shift_d = shift_q >> SYM_W;
        idx_d = idx_q + 1'b1;
        hcnt_d = hold_q;
      end
    end else if (state_q[S_PAUSE]) begin
      if (!stall) state_d = ST_EMIT;
    end else if (state_q[S_GAP]) begin
      gap_d = gap_q + 1'b1;
      if (gap_q == GW'(GAP_CYC - 1)) state_d = ST_DONE;
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      hold_q <= '0;
      hcnt_q <= '0;
      idx_q <= '0;
      gap_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      hold_q <= hold_d;
      hcnt_q <= hcnt_d;
      idx_q <= idx_d;
      gap_q <= gap_d;
    end
  end

  // symbol stays on the wires through a pause so the consumer sees no glitch
  assign {a, b, c} = (state_q[S_EMIT] | state_q[S_PAUSE]) ? shift_q[SYM_W-1:0] : IDLE_SYM;
  assign sym_valid = state_q[S_EMIT] & ~stall;
  assign sym_idx = idx_q;
  assign busy = ~state_q[S_IDLE];
  assign in_ready = state_q[S_IDLE];
  assign done = state_q[S_DONE];
endmodule

// File: tb/tb_abc_seq_tx.sv
// tb_abc_seq_tx: random and directed frames checked against a precomputed expected output trace
module tb_abc_seq_tx;
  localparam int N = 4;
  localparam int G = 2;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, stall, a, b, c, sym_valid, busy, done;
  logic [11:0] in_data;
  logic [1:0] in_hold, sym_idx;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0] abc;
    logic       v;
    logic [1:0] idx;
    logic       busy;
    logic       done;
    logic       rdy;
    logic       ck_idx;
  } exp_t;

  always #5 clk = ~clk;

  abc_seq_tx #(.N_SYM(N), .HOLD_W(2), .GAP_CYC(G)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_hold(in_hold), .stall(stall), .a(a), .b(b), .c(c), .sym_valid(sym_valid),
    .sym_idx(sym_idx), .busy(busy), .done(done)
  );

  function automatic exp_t mk(logic [2:0] abc, logic v, int idx, logic bz, logic dn, logic rdy, logic ck);
    exp_t e;
    e.abc = abc;
    e.v = v;
    e.idx = 2'(idx);
    e.busy = bz;
    e.done = dn;
    e.rdy = rdy;
    e.ck_idx = ck;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cmp(input exp_t e, input string tag);
    check({tag, ".abc"}, 32'({a, b, c}), 32'(e.abc));
    check({tag, ".sym_valid"}, 32'(sym_valid), 32'(e.v));
    check({tag, ".busy"}, 32'(busy), 32'(e.busy));
    check({tag, ".done"}, 32'(done), 32'(e.done));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(e.rdy));
    if (e.ck_idx) check({tag, ".sym_idx"}, 32'(sym_idx), 32'(e.idx));
  endtask

  task automatic step(input logic v, input logic [11:0] d, input logic [1:0] h, input logic s, input logic r);
    @(negedge clk);
    in_valid = v;
    in_data = d;
    in_hold = h;
    stall = s;
    rst = r;
    #1;
  endtask

  // mode: 0 no stall, 1 random stall, 2 stall at offsets 3..4; rst_at: offset of a mid-frame reset or -1
  task automatic frame(input logic [11:0] d, input logic [1:0] h, input int mode, input int rst_at,
                       input bit vhold, input string tag);
    logic st[128];
    exp_t tr[$];
    int o, counted, total, k;
    bit pause;
    for (int i = 0; i < 128; i++) st[i] = (mode == 1) ? ($urandom_range(3) == 0) : 1'b0;
    if (mode == 2) begin
      st[3] = 1'b1;
      st[4] = 1'b1;
    end
    tr.push_back(mk(3'b000, 0, 0, 1, 0, 0, 1));
    o = 2;
    counted = 0;
    total = N * (int'(h) + 1);
    pause = 0;
    while (counted < total) begin
      if (o >= 100) st[o] = 1'b0;
      k = counted / (int'(h) + 1);
      if (pause) begin
        tr.push_back(mk(d[k*3+:3], 0, k, 1, 0, 0, 1));
        pause = st[o];
      end else if (st[o]) begin
        tr.push_back(mk(d[k*3+:3], 0, k, 1, 0, 0, 1));
        pause = 1;
      end else begin
        tr.push_back(mk(d[k*3+:3], 1, k, 1, 0, 0, 1));
        counted++;
      end
      o++;
    end
    repeat (G) tr.push_back(mk(3'b000, 0, 0, 1, 0, 0, 0));
    tr.push_back(mk(3'b000, 0, 0, 1, 1, 0, 0));
    step(1'b1, d, h, 1'($urandom), 1'b0);
    cmp(mk(3'b000, 0, 0, 0, 0, 1, 0), {tag, ".accept"});
    for (int i = 0; i < tr.size(); i++) begin
      step(vhold ? 1'b1 : 1'($urandom), 12'($urandom), 2'($urandom), st[i+1], 1'(i + 1 == rst_at));
      cmp(tr[i], $sformatf("%s.t%0d", tag, i + 1));
      if (i + 1 == rst_at) begin
        step(1'b0, 12'd0, 2'd0, 1'b0, 1'b0);
        cmp(mk(3'b000, 0, 0, 0, 0, 1, 1), {tag, ".after_rst"});
        return;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    stall = 1'b0;
    in_data = '0;
    in_hold = '0;
    step(1'b0, 12'd0, 2'd0, 1'b0, 1'b1);
    step(1'b0, 12'd0, 2'd0, 1'b0, 1'b1);
    step(1'b0, 12'd0, 2'd0, 1'b0, 1'b0);
    cmp(mk(3'b000, 0, 0, 0, 0, 1, 1), "reset");
    frame(12'b101_011_110_001, 2'd0, 0, -1, 0, "hold0");
    frame(12'b101_011_110_001, 2'd2, 0, -1, 0, "hold2");
    frame(12'b101_011_110_001, 2'd0, 2, -1, 0, "stall");
    frame(12'hA5C, 2'd1, 0, -1, 1, "b2b_a");
    frame(12'h3C9, 2'd0, 0, -1, 1, "b2b_b");
    frame(12'b101_011_110_001, 2'd0, 0, 4, 0, "midrst");
    frame(12'h777, 2'd3, 0, -1, 0, "postrst");
    repeat (40) begin
      frame(12'($urandom), 2'($urandom), 1, ($urandom_range(7) == 0) ? int'($urandom_range(1, 12)) : -1,
            1'($urandom), "rnd");
      if ($urandom_range(1) == 1) begin
        step(1'b0, 12'($urandom), 2'($urandom), 1'($urandom), 1'b0);
        cmp(mk(3'b000, 0, 0, 0, 0, 1, 0), "idle");
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
